fd_latch: RTL and testbench

- IF/ID pipeline boundary that sits directly downstream of the PC stage and the synchronous instruction memory.
- The imem returns an instruction one cycle after its address is presented. This block delays the PC stage's pc_plus_4 by one cycle to align it with the returned word, then registers the pair for decode.
- Handles stall (including skid capture of the in-flight word), flush (bubble injection) and a valid bit.
- Drives pc_ena back to the PC stage.

---
 rtl/fd_pkg.sv | 13 +
 rtl/fd_hold_buf.sv | 57 +++++
 rtl/fd_latch.sv | 90 +++++++++
 tb/tb_fd_latch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared definitions for the IF/ID boundary: default widths, the bubble
// encoding and the skid-buffer state encoding.
package fd_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/fd_hold_buf.sv
// One-entry skid buffer for the IF/ID boundary. It captures the word that
// is arriving from imem when decode stalls, and keeps it until the stall
// releases. Flush discards any held word.
module fd_hold_buf
    import fd_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,
    input  logic              release_en,
    input  logic              flush,
    input  logic [DATA_W-1:0] insn_in,
    output logic              held,
    output logic [DATA_W-1:0] hold_insn
);

    hold_state_t state_q;
    hold_state_t state_d;

    // State register; reset empties the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush always empties, otherwise fill on stall, drain on release.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (capture)    state_d = HELD;
                HELD:    if (release_en) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Capture only on entry to HELD; later repeats of the same fetch are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_insn <= NOP_WORD;
        end else if (!flush && (state_q == EMPTY) && capture) begin
            hold_insn <= insn_in;
        end
    end

    assign held = (state_q == HELD);

endmodule

// File: rtl/fd_latch.sv
// IF/ID pipeline register. Delays pc_plus_4 by one cycle to line it up with
// the synchronous imem read data, then registers the pair for decode, with
// stall (skid capture), flush (bubble) and a valid bit.
// Optional: define FD_STALL_COUNT_EN to add a saturating stall_count output.
module fd_latch
    import fd_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_plus_4_in,
    input  logic [DATA_W-1:0] insn_in,
    input  logic              fetch_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              pc_ena,
    output logic [DATA_W-1:0] fd_insn,
    output logic [DATA_W-1:0] fd_pc_plus_4,
    output logic              fd_valid
`ifdef FD_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    logic [DATA_W-1:0] pc_d;
    logic              valid_d;
    logic              held;
    logic [DATA_W-1:0] hold_insn;

    assign pc_ena = !stall || flush;

    fd_hold_buf #(
        .DATA_W   (DATA_W),
        .NOP_WORD (NOP_WORD)
    ) u_hold_buf (
        .clock      (clock),
        .reset      (reset),
        .capture    (stall),
        .release_en (!stall),
        .flush      (flush),
        .insn_in    (insn_in),
        .held       (held),
        .hold_insn  (hold_insn)
    );

    // Alignment stage: follows the PC register so pc_d matches the word imem returns next.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (flush) begin
            pc_d    <= pc_plus_4_in;
            valid_d <= 1'b0;
        end else if (pc_ena) begin
            pc_d    <= pc_plus_4_in;
            valid_d <= fetch_valid;
        end
    end

    // Output stage: bubble on flush, hold on stall, otherwise take the skid word first.
    always_ff @(posedge clock) begin
        if (reset) begin
            fd_insn      <= NOP_WORD;
            fd_pc_plus_4 <= '0;
            fd_valid     <= 1'b0;
        end else if (flush) begin
            fd_insn  <= NOP_WORD;
            fd_valid <= 1'b0;
        end else if (!stall) begin
            fd_insn      <= held ? hold_insn : insn_in;
            fd_pc_plus_4 <= pc_d;
            fd_valid     <= valid_d;
        end
    end

`ifdef FD_STALL_COUNT_EN
    // Saturating count of edges where the pipeline was actually frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && !flush && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fd_latch.sv
// Self-checking bench for fd_latch. The bench plays the PC stage and a
// synchronous imem, and predicts decode's view as an ordered stream of
// fetch records: every accepted fetch must reach decode exactly once, in
// order, carrying the imem word for its own address.
module tb_fd_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_plus_4_in;
    logic [31:0] insn_in;
    logic        fetch_valid;
    logic        stall;
    logic        flush;
    logic        pc_ena;
    logic [31:0] fd_insn;
    logic [31:0] fd_pc_plus_4;
    logic        fd_valid;
`ifdef FD_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clock = ~clock;

    fd_latch dut (
        .clock        (clock),
        .reset        (reset),
        .pc_plus_4_in (pc_plus_4_in),
        .insn_in      (insn_in),
        .fetch_valid  (fetch_valid),
        .stall        (stall),
        .flush        (flush),
        .pc_ena       (pc_ena),
        .fd_insn      (fd_insn),
        .fd_pc_plus_4 (fd_pc_plus_4),
        .fd_valid     (fd_valid)
`ifdef FD_STALL_COUNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    typedef struct {
        logic [31:0] pc4;
        logic        v;
    } fetch_t;

    fetch_t      pend[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] pc         = 32'd0;
    logic [31:0] imem_q     = 32'd0;
    logic [31:0] exp_insn   = 32'd0;
    logic [31:0] exp_pc4    = 32'd0;
    logic        exp_valid  = 1'b0;
    logic        exp_insn_chk = 1'b0;
    int          exp_cnt    = 0;

    // Distinct, never-zero imem contents derived from the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance PC stage/imem/model, then check decode's view.
    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic fv);
        fetch_t rec;
        reset        = r;
        stall        = s;
        flush        = f;
        fetch_valid  = fv;
        pc_plus_4_in = pc + 32'd4;
        insn_in      = imem_q;
        #1;
        checkOutput("pc_ena", {31'd0, pc_ena}, {31'd0, (!s || f)});
        @(posedge clock);
        if (r) begin
            exp_insn     = 32'd0;
            exp_pc4      = 32'd0;
            exp_valid    = 1'b0;
            exp_insn_chk = 1'b1;
            pend.delete();
            pend.push_back('{pc4: 32'd0, v: 1'b0});
            exp_cnt = 0;
        end else if (f) begin
            exp_insn     = 32'd0;
            exp_valid    = 1'b0;
            exp_insn_chk = 1'b1;
            pend.delete();
            pend.push_back('{pc4: pc + 32'd4, v: 1'b0});
        end else if (!s) begin
            if (pend.size() > 0) begin
                rec = pend.pop_front();
                exp_pc4      = rec.pc4;
                exp_valid    = rec.v;
                exp_insn     = word_of(rec.pc4 - 32'd4);
                exp_insn_chk = rec.v;
            end
            pend.push_back('{pc4: pc + 32'd4, v: fv});
        end
        if (!r && s && !f && exp_cnt != 65535) exp_cnt++;
        imem_q = word_of(pc);
        if (r) pc = 32'd0;
        else if (f) pc = {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
        else if (!s) pc = pc + 32'd4;
        #1;
        checkOutput("fd_valid", {31'd0, fd_valid}, {31'd0, exp_valid});
        checkOutput("fd_pc_plus_4", fd_pc_plus_4, exp_pc4);
        if (exp_insn_chk) checkOutput("fd_insn", fd_insn, exp_insn);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        pc_plus_4_in = 32'd0; insn_in = 32'd0;
        @(posedge clock);
        #1;
        // Reset for two cycles, then a clean run, a 3-cycle stall and more fetches.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        // Single-cycle flush, then recovery.
        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        // Stall into HELD, then stall together with flush.
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        // One non-fetch slot between real fetches.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 35),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 85));
        end
`ifdef FD_STALL_COUNT_EN
        applyStimulus(1, 0, 0, 1);
        checkOutput("stall_count_reset", {16'd0, stall_count}, 32'(exp_cnt));
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(0, 1, 0, 1);
            if (i % 5000 == 0) checkOutput("stall_count", {16'd0, stall_count}, 32'(exp_cnt));
        end
        checkOutput("stall_count_sat", {16'd0, stall_count}, 32'h0000_FFFF);
        applyStimulus(0, 1, 0, 1);
        checkOutput("stall_count_stick", {16'd0, stall_count}, 32'h0000_FFFF);
        applyStimulus(1, 1, 0, 1);
        checkOutput("stall_count_clear", {16'd0, stall_count}, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
